onehot_demux: RTL and testbench
===============================

ONEHOT_DEMUX -- requirements
Module: onehot_demux

Interface
REQ-001 SHALL have parameter PORTS, default 4, number of output ports (>= 2).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, beat width in bits (>= 1).
REQ-003 SHALL have port i_clock  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_areset  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port i_valid  input  1  upstream beat valid.
REQ-006 SHALL have port o_ready  output  1  upstream ready; a beat transfers when i_valid and o_ready are both 1.
REQ-007 SHALL have port i_data  input  DATA_WIDTH  upstream beat payload.
REQ-008 SHALL have port i_select  input  PORTS  onehot destination, sampled with the beat.
REQ-009 SHALL have port o_valid  output  PORTS  per-port downstream valid.
REQ-010 SHALL have port i_ready  input  PORTS  per-port downstream ready.
REQ-011 SHALL have port o_data  output  PORTS*DATA_WIDTH  per-port payload; port k occupies bits [(k+1)*DATA_WIDTH-1 -: DATA_WIDTH].
REQ-012 SHALL have port o_error  output  1  one-cycle pulse when an invalid select is dropped.

Function
REQ-013 SHALL hold up to two accepted beats: a head register driving the outputs and a skid register.
REQ-014 SHALL use an occupancy FSM with states EMPTY, ONE and TWO.
REQ-015 SHALL drive o_ready = 1 in EMPTY and ONE, and 0 in TWO, as a registered or state-decoded signal with no combinational path from i_ready.
REQ-016 SHALL present an accepted beat on the outputs in the cycle after acceptance (latency 1) when the head register is free.
REQ-017 SHALL assert only o_valid[k] for head select bit k; all other o_valid bits SHALL be 0.
REQ-018 SHALL drive o_data slice k with the head payload and every other slice with all zeros.
REQ-019 SHALL retire the head when o_valid[k] and i_ready[k] are both 1; i_ready on other ports SHALL be ignored.
REQ-020 SHALL use these FSM transitions:
  - EMPTY to ONE on accept.
  - ONE to EMPTY on retire without accept.
  - ONE stays ONE on simultaneous retire and accept; the new beat goes to the head.
  - ONE to TWO on accept without retire; the beat goes to skid.
  - TWO to ONE on retire; skid moves to head.
REQ-021 SHALL sustain one beat per cycle when the selected port's i_ready is held at 1.
REQ-022 SHALL hold the head payload and select stable while o_valid is asserted and unretired.
REQ-023 SHALL treat an accepted beat whose i_select is zero or multi-hot as invalid:
  - accept it (o_ready behaviour unchanged);
  - not store it and leave the FSM state unchanged;
  - pulse o_error high for exactly the next cycle.
REQ-024 SHALL ignore i_data and i_select when i_valid = 0.
REQ-025 SHALL keep the order of valid beats across ports identical to the acceptance order; there is no per-port bypass, so a stalled port blocks all ports (head-of-line).

Reset
REQ-026 SHALL on i_areset = 1 immediately force:
  - FSM to EMPTY;
  - o_valid = 0, o_error = 0, o_ready = 0;
  - head and skid payload and select = 0.
REQ-027 SHALL drive o_ready = 1 from the first rising clock edge after i_areset deasserts.
REQ-028 SHALL discard any held beats on reset mid-operation with no partial output.

Structure
REQ-029 SHALL place the FSM state enum (EMPTY, ONE, TWO) and an is_onehot function in a shared package, onehot_demux_pkg.
REQ-030 SHALL implement the two-entry storage and occupancy FSM as one sub-module, skid_buffer, carrying select and payload; the top adds select validation and per-port fan-out.

Verification
REQ-031 SHALL cover single beat: i_select=0100, i_data=0x5A, all i_ready=1 -> next cycle o_valid=0100, port 2 data 0x5A, other slices 0x00; following cycle o_valid=0000.
REQ-032 SHALL cover backpressure: port 1 i_ready=0, three beats to port 1 (0x11, 0x22, 0x33) -> o_ready drops after the second accept; third beat is held upstream; releasing i_ready yields 0x11, 0x22, 0x33 in order with no loss.
REQ-033 SHALL cover streaming: 16 back-to-back beats rotating across ports 0..3 with all i_ready=1 -> 16 outputs in 16 consecutive cycles, each on the correct port.
REQ-034 SHALL cover invalid select: i_select=0000, then i_select=0011 -> o_error pulses one cycle each, no o_valid asserted, FSM stays EMPTY.
REQ-035 SHALL cover mid-operation reset: reset asserted in TWO with port 3 stalled -> o_valid=0000 immediately (async); after release o_ready=1 and no stale beat appears.
REQ-036 SHALL cover a stalled head: head on port 0 stalled while i_ready[1]=1 -> port 1 receives nothing until port 0 retires.

Source files
------------

// File: rtl/onehot_demux_pkg.sv
// rtl/onehot_demux_pkg.sv - shared occupancy states and select helper for the onehot demux
package onehot_demux_pkg;

  // Widest select vector is_onehot can judge; PORTS must not exceed this.
  localparam int MAX_PORTS = 64;

  // Occupancy of the two-entry head/skid store.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_state_t;

  // True when exactly one bit of the (zero-extended) select is set.
  function automatic logic is_onehot(input logic [MAX_PORTS-1:0] sel);
    logic [MAX_PORTS-1:0] low_cleared;
    low_cleared = sel & (sel - MAX_PORTS'(1));
    return (sel != '0) && (low_cleared == '0);
  endfunction

endpackage

// File: rtl/onehot_demux_skid_buffer.sv
// rtl/onehot_demux_skid_buffer.sv - two-entry head/skid store with occupancy FSM
module skid_buffer
  import onehot_demux_pkg::*;
#(
  parameter int PORTS      = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PORTS-1:0]      in_sel,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [PORTS-1:0]      out_sel,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_pop
);

  occ_state_t            state;
  logic                  ready_q;
  logic [PORTS-1:0]      head_sel;
  logic [DATA_WIDTH-1:0] head_data;
  logic [PORTS-1:0]      skid_sel;
  logic [DATA_WIDTH-1:0] skid_data;
  logic                  push;
  logic                  pop;

  // ready is a register, so a beat is only taken when a slot is guaranteed free.
  assign push = in_valid && ready_q;
  assign pop  = out_pop && (state != EMPTY);

  // Occupancy FSM; ready is re-registered on every transition so it never
  // depends combinationally on the downstream pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      ready_q   <= 1'b0;
      head_sel  <= '0;
      head_data <= '0;
      skid_sel  <= '0;
      skid_data <= '0;
    end else begin
      case (state)
        EMPTY: begin
          ready_q <= 1'b1;
          if (push) begin
            head_sel  <= in_sel;
            head_data <= in_data;
            state     <= ONE;
          end
        end
        ONE: begin
          if (pop && push) begin
            head_sel  <= in_sel;
            head_data <= in_data;
            ready_q   <= 1'b1;
          end else if (pop) begin
            state   <= EMPTY;
            ready_q <= 1'b1;
          end else if (push) begin
            skid_sel  <= in_sel;
            skid_data <= in_data;
            state     <= TWO;
            ready_q   <= 1'b0;
          end
        end
        TWO: begin
          // ready is low here, so no push can coincide with the pop.
          if (pop) begin
            head_sel  <= skid_sel;
            head_data <= skid_data;
            state     <= ONE;
            ready_q   <= 1'b1;
          end
        end
        default: begin
          state   <= EMPTY;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = (state != EMPTY);
  assign out_sel   = head_sel;
  assign out_data  = head_data;

endmodule

// File: rtl/onehot_demux.sv
// rtl/onehot_demux.sv - onehot-addressed 1:N stream demux with head-of-line ordering
module onehot_demux
  import onehot_demux_pkg::*;
#(
  parameter int PORTS      = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                        i_clock,
  input  logic                        i_areset,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic [DATA_WIDTH-1:0]       i_data,
  input  logic [PORTS-1:0]            i_select,
  output logic [PORTS-1:0]            o_valid,
  input  logic [PORTS-1:0]            i_ready,
  output logic [PORTS*DATA_WIDTH-1:0] o_data,
  output logic                        o_error
);

  logic                  sel_ok;
  logic                  accept;
  logic                  head_valid;
  logic [PORTS-1:0]      head_sel;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  retire;

  // Bad selects are still handshaken upstream but never reach the store.
  assign sel_ok = is_onehot(MAX_PORTS'(i_select));
  assign accept = i_valid && o_ready;

  skid_buffer #(
    .PORTS      (PORTS),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_store (
    .clk       (i_clock),
    .rst       (i_areset),
    .in_valid  (i_valid && sel_ok),
    .in_ready  (o_ready),
    .in_sel    (i_select),
    .in_data   (i_data),
    .out_valid (head_valid),
    .out_sel   (head_sel),
    .out_data  (head_data),
    .out_pop   (retire)
  );

  // Fan the head out to its selected port only; other ports see zero.
  always_comb begin
    o_valid = '0;
    o_data  = '0;
    for (int k = 0; k < PORTS; k++) begin
      if (head_valid && head_sel[k]) begin
        o_valid[k]                             = 1'b1;
        o_data[k*DATA_WIDTH +: DATA_WIDTH]     = head_data;
      end
    end
  end

  // Only the addressed port's ready can retire the head.
  assign retire = |(o_valid & i_ready);

  // One-cycle error pulse for each dropped invalid-select beat.
  always_ff @(posedge i_clock or posedge i_areset) begin
    if (i_areset) begin
      o_error <= 1'b0;
    end else begin
      o_error <= accept && !sel_ok;
    end
  end

endmodule

// File: tb/tb_onehot_demux.sv
// tb/tb_onehot_demux.sv - directed self-checking bench for onehot_demux
module tb_onehot_demux;

  logic        clk;
  logic        rst;
  logic        i_valid;
  logic        o_ready;
  logic [7:0]  i_data;
  logic [3:0]  i_select;
  logic [3:0]  o_valid;
  logic [3:0]  i_ready;
  logic [31:0] o_data;
  logic        o_error;

  int passed;
  int total;

  onehot_demux #(.PORTS(4), .DATA_WIDTH(8)) dut (
    .i_clock  (clk),
    .i_areset (rst),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_data   (i_data),
    .i_select (i_select),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_data   (o_data),
    .o_error  (o_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst = 1'b1; i_valid = 1'b0; i_data = 8'h00; i_select = 4'b0000; i_ready = 4'b1111;
    #3;
    total++; if (o_valid !== 4'b0000) $display("FAIL reset_valid: got %b want 0000", o_valid); else passed++;
    total++; if (o_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", o_ready); else passed++;
    total++; if (o_error !== 1'b0) $display("FAIL reset_error: got %b want 0", o_error); else passed++;
    total++; if (o_data !== 32'h0) $display("FAIL reset_data: got %h want 00000000", o_data); else passed++;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    total++; if (o_ready !== 1'b1) $display("FAIL ready_after_reset: got %b want 1", o_ready); else passed++;
  endtask

  task automatic test_single();
    i_ready = 4'b1111;
    i_valid = 1'b1; i_select = 4'b0100; i_data = 8'h5A;
    @(negedge clk);
    i_valid = 1'b0; i_select = 4'b0000; i_data = 8'h00;
    total++; if (o_valid !== 4'b0100) $display("FAIL single_valid: got %b want 0100", o_valid); else passed++;
    total++; if (o_data !== 32'h005A0000) $display("FAIL single_data: got %h want 005a0000", o_data); else passed++;
    @(negedge clk);
    total++; if (o_valid !== 4'b0000) $display("FAIL single_drain: got %b want 0000", o_valid); else passed++;
  endtask

  task automatic test_backpressure();
    i_ready = 4'b1101;
    total++; if (o_ready !== 1'b1) $display("FAIL bp_ready0: got %b want 1", o_ready); else passed++;
    i_valid = 1'b1; i_select = 4'b0010; i_data = 8'h11;
    @(negedge clk);
    total++; if (o_ready !== 1'b1) $display("FAIL bp_ready1: got %b want 1", o_ready); else passed++;
    total++; if (o_data !== 32'h00001100) $display("FAIL bp_head11: got %h want 00001100", o_data); else passed++;
    i_data = 8'h22;
    @(negedge clk);
    total++; if (o_ready !== 1'b0) $display("FAIL bp_ready_drop: got %b want 0", o_ready); else passed++;
    i_data = 8'h33;
    @(negedge clk);
    total++; if (o_ready !== 1'b0) $display("FAIL bp_ready_held: got %b want 0", o_ready); else passed++;
    total++; if (o_valid !== 4'b0010 || o_data !== 32'h00001100)
      $display("FAIL bp_stall_head: got %b/%h want 0010/00001100", o_valid, o_data); else passed++;
    i_ready = 4'b1111;
    @(negedge clk);
    total++; if (o_valid !== 4'b0010 || o_data !== 32'h00002200)
      $display("FAIL bp_out22: got %b/%h want 0010/00002200", o_valid, o_data); else passed++;
    total++; if (o_ready !== 1'b1) $display("FAIL bp_ready_back: got %b want 1", o_ready); else passed++;
    @(negedge clk);
    i_valid = 1'b0;
    total++; if (o_valid !== 4'b0010 || o_data !== 32'h00003300)
      $display("FAIL bp_out33: got %b/%h want 0010/00003300", o_valid, o_data); else passed++;
    @(negedge clk);
    total++; if (o_valid !== 4'b0000) $display("FAIL bp_drain: got %b want 0000", o_valid); else passed++;
  endtask

  task automatic test_streaming();
    logic [3:0]  exp_sel;
    logic [31:0] exp_data;
    logic [7:0]  d;
    i_ready = 4'b1111;
    for (int i = 0; i <= 16; i++) begin
      if (i > 0) begin
        exp_sel  = 4'b0001 << ((i - 1) % 4);
        d        = 8'hA0 + 8'(i - 1);
        exp_data = 32'(d) << (8 * ((i - 1) % 4));
        total++; if (o_valid !== exp_sel || o_data !== exp_data)
          $display("FAIL stream_beat%0d: got %b/%h want %b/%h", i - 1, o_valid, o_data, exp_sel, exp_data);
        else passed++;
        total++; if (o_ready !== 1'b1) $display("FAIL stream_ready%0d: got %b want 1", i - 1, o_ready); else passed++;
      end
      if (i < 16) begin
        i_valid = 1'b1; i_select = 4'b0001 << (i % 4); i_data = 8'hA0 + 8'(i);
      end else begin
        i_valid = 1'b0; i_select = 4'b0000;
      end
      @(negedge clk);
    end
    total++; if (o_valid !== 4'b0000) $display("FAIL stream_drain: got %b want 0000", o_valid); else passed++;
  endtask

  task automatic test_invalid();
    i_ready = 4'b1111;
    i_valid = 1'b1; i_select = 4'b0000; i_data = 8'hFF;
    @(negedge clk);
    total++; if (o_error !== 1'b1) $display("FAIL inv_zero_err: got %b want 1", o_error); else passed++;
    total++; if (o_valid !== 4'b0000) $display("FAIL inv_zero_valid: got %b want 0000", o_valid); else passed++;
    i_select = 4'b0011;
    @(negedge clk);
    i_valid = 1'b0; i_select = 4'b0000;
    total++; if (o_error !== 1'b1) $display("FAIL inv_multi_err: got %b want 1", o_error); else passed++;
    total++; if (o_valid !== 4'b0000) $display("FAIL inv_multi_valid: got %b want 0000", o_valid); else passed++;
    @(negedge clk);
    total++; if (o_error !== 1'b0) $display("FAIL inv_err_clear: got %b want 0", o_error); else passed++;
    total++; if (o_ready !== 1'b1 || o_valid !== 4'b0000)
      $display("FAIL inv_empty: got ready %b valid %b want 1/0000", o_ready, o_valid); else passed++;
  endtask

  task automatic test_midreset();
    i_ready = 4'b0111;
    i_valid = 1'b1; i_select = 4'b1000; i_data = 8'h31;
    @(negedge clk);
    i_data = 8'h32;
    @(negedge clk);
    i_valid = 1'b0; i_select = 4'b0000;
    total++; if (o_ready !== 1'b0 || o_valid !== 4'b1000)
      $display("FAIL mr_two: got ready %b valid %b want 0/1000", o_ready, o_valid); else passed++;
    #2 rst = 1'b1;
    #1;
    total++; if (o_valid !== 4'b0000 || o_data !== 32'h0)
      $display("FAIL mr_async: got %b/%h want 0000/00000000", o_valid, o_data); else passed++;
    @(negedge clk); rst = 1'b0; i_ready = 4'b1111;
    @(negedge clk);
    total++; if (o_ready !== 1'b1 || o_valid !== 4'b0000)
      $display("FAIL mr_after: got ready %b valid %b want 1/0000", o_ready, o_valid); else passed++;
    @(negedge clk);
    total++; if (o_valid !== 4'b0000) $display("FAIL mr_stale: got %b want 0000", o_valid); else passed++;
  endtask

  task automatic test_hol();
    i_ready = 4'b0010;
    i_valid = 1'b1; i_select = 4'b0001; i_data = 8'h40;
    @(negedge clk);
    total++; if (o_valid !== 4'b0001 || o_data !== 32'h00000040)
      $display("FAIL hol_head: got %b/%h want 0001/00000040", o_valid, o_data); else passed++;
    i_select = 4'b0010; i_data = 8'h41;
    @(negedge clk);
    i_valid = 1'b0; i_select = 4'b0000;
    total++; if (o_valid !== 4'b0001) $display("FAIL hol_block1: got %b want 0001", o_valid); else passed++;
    @(negedge clk);
    total++; if (o_valid !== 4'b0001) $display("FAIL hol_block2: got %b want 0001", o_valid); else passed++;
    i_ready = 4'b0011;
    @(negedge clk);
    total++; if (o_valid !== 4'b0010 || o_data !== 32'h00004100)
      $display("FAIL hol_release: got %b/%h want 0010/00004100", o_valid, o_data); else passed++;
    @(negedge clk);
    total++; if (o_valid !== 4'b0000) $display("FAIL hol_drain: got %b want 0000", o_valid); else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_single();
    test_backpressure();
    test_streaming();
    test_invalid();
    test_midreset();
    test_hol();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
